// File: rtl/glitch_trig_seq.sv
// Trigger sequencer for the clock glitcher: waits for an armed ext_trig edge,
// counts a delay, then emits a train of trig pulses separated by low gaps.
module glitch_trig_seq #(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic               ext_trig,
    input  logic [DELAY_W-1:0] delay,
    input  logic [WIDTH_W-1:0] pulse_width,
    input  logic [DELAY_W-1:0] gap,
    input  logic [COUNT_W-1:0] repeat_count,
    output logic               trig,
    output logic               armed,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic sync1_q, sync2_q, hist_q;
    logic trig_q, trig_d;
    logic edge_det;

    logic [DELAY_W-1:0] cfg_delay_q, cfg_delay_d;
    logic [WIDTH_W-1:0] cfg_pw_q, cfg_pw_d;
    logic [DELAY_W-1:0] cfg_gap_q, cfg_gap_d;
    logic [COUNT_W-1:0] cfg_rep_q, cfg_rep_d;

    logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [WIDTH_W-1:0] width_cnt_q, width_cnt_d;
    logic [COUNT_W-1:0] rep_cnt_q, rep_cnt_d;

    logic [WIDTH_W-1:0] pw_eff;
    logic [DELAY_W-1:0] gap_eff;
    logic [COUNT_W-1:0] rep_eff;

    assign edge_det = sync2_q & ~hist_q;
    assign pw_eff   = (cfg_pw_q  == '0) ? WIDTH_W'(1) : cfg_pw_q;
    assign gap_eff  = (cfg_gap_q == '0) ? DELAY_W'(1) : cfg_gap_q;
    assign rep_eff  = (cfg_rep_q == '0) ? COUNT_W'(1) : cfg_rep_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= 1'b0;
            trig_q      <= 1'b0;
            cfg_delay_q <= '0;
            cfg_pw_q    <= '0;
            cfg_gap_q   <= '0;
            cfg_rep_q   <= '0;
            delay_cnt_q <= '0;
            width_cnt_q <= '0;
            rep_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= ext_trig;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            trig_q      <= trig_d;
            cfg_delay_q <= cfg_delay_d;
            cfg_pw_q    <= cfg_pw_d;
            cfg_gap_q   <= cfg_gap_d;
            cfg_rep_q   <= cfg_rep_d;
            delay_cnt_q <= delay_cnt_d;
            width_cnt_q <= width_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    // delay_cnt is shared between the initial delay and the inter-pulse gap.
    always_comb begin
        state_d     = state_q;
        cfg_delay_d = cfg_delay_q;
        cfg_pw_d    = cfg_pw_q;
        cfg_gap_d   = cfg_gap_q;
        cfg_rep_d   = cfg_rep_q;
        delay_cnt_d = delay_cnt_q;
        width_cnt_d = width_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d     = ST_ARMED;
                        cfg_delay_d = delay;
                        cfg_pw_d    = pulse_width;
                        cfg_gap_d   = gap;
                        cfg_rep_d   = repeat_count;
                    end
                end
                ST_ARMED: begin
                    if (edge_det) begin
                        rep_cnt_d = rep_eff;
                        if (cfg_delay_q != '0) begin
                            state_d     = ST_DELAY;
                            delay_cnt_d = cfg_delay_q;
                        end else begin
                            state_d     = ST_PULSE;
                            width_cnt_d = pw_eff;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_q <= DELAY_W'(1)) begin
                        state_d     = ST_PULSE;
                        width_cnt_d = pw_eff;
                    end else begin
                        delay_cnt_d = delay_cnt_q - DELAY_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (width_cnt_q <= WIDTH_W'(1)) begin
                        rep_cnt_d = rep_cnt_q - COUNT_W'(1);
                        if (rep_cnt_q <= COUNT_W'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d     = ST_GAP;
                            delay_cnt_d = gap_eff;
                        end
                    end else begin
                        width_cnt_d = width_cnt_q - WIDTH_W'(1);
                    end
                end
                ST_GAP: begin
                    if (delay_cnt_q <= DELAY_W'(1)) begin
                        state_d     = ST_PULSE;
                        width_cnt_d = pw_eff;
                    end else begin
                        delay_cnt_d = delay_cnt_q - DELAY_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // trig is registered from the next state so it is high exactly in PULSE.
    always_comb begin
        trig_d = (state_d == ST_PULSE);
        trig   = trig_q;
        armed  = (state_q == ST_ARMED);
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
    end

endmodule
